decoder_lut_pipe: RTL and testbench



---
 rtl/decoder_lut_pipe.sv | 156 +++++++++++++++
 tb/tb_decoder_lut_pipe.sv | 347 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/decoder_lut_pipe.sv
// ----------------------------------------------------------------------------
// decoder_lut_pipe
//
// Decodes every raw IN_DW-bit macro code of a CHANNEL_NUM x MACRO_NUM lane
// array into a signed OUT_DW-bit value. All lanes share one decode table.
// The block has a 2-stage valid/ready pipeline (capture, then lookup) and
// counts the beats delivered downstream.
//
// Default table entry for code c:
//   sum_k (k+1)*c[k] - 2^(OUT_DW-1), saturated to the signed OUT_DW range.
//
// Build option:
//   DECODER_LUT_WR_EN  defined   : the table is a writable register file that
//                                  resets to the default contents. The cfg_*
//                                  ports write one entry per cycle.
//                      undefined : the table is a constant ROM and the cfg_*
//                                  ports do not exist.
//
// Ports:
//   clk, rst_n   clock (rising edge) and asynchronous active-low reset
//   data_e       input beat valid
//   data_ready   input beat ready; a beat is accepted when data_e && data_ready
//   data_in      raw unsigned codes, [CHANNEL_NUM][MACRO_NUM] x IN_DW
//   data_out     registered decoded values, [CHANNEL_NUM][MACRO_NUM] x OUT_DW
//   data_e_out   output beat valid
//   out_ready    downstream ready; a beat leaves when data_e_out && out_ready
//   cfg_we/addr/data  table write port (DECODER_LUT_WR_EN only)
//   beat_cnt     number of beats delivered downstream, wraps at 2^CNT_DW
// ----------------------------------------------------------------------------
module decoder_lut_pipe #(
    parameter int CHANNEL_NUM = 512,
    parameter int MACRO_NUM   = 32,
    parameter int IN_DW       = 5,
    parameter int OUT_DW      = 4,
    parameter int CNT_DW      = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     data_e,
    output logic                     data_ready,
    input  logic [IN_DW-1:0]         data_in  [CHANNEL_NUM][MACRO_NUM],
    output logic signed [OUT_DW-1:0] data_out [CHANNEL_NUM][MACRO_NUM],
    output logic                     data_e_out,
    input  logic                     out_ready,
`ifdef DECODER_LUT_WR_EN
    input  logic                     cfg_we,
    input  logic [IN_DW-1:0]         cfg_addr,
    input  logic signed [OUT_DW-1:0] cfg_data,
`endif
    output logic [CNT_DW-1:0]        beat_cnt
);

    localparam int LUT_DEPTH = 1 << IN_DW;
    localparam int OUT_MAX   = (1 << (OUT_DW - 1)) - 1;
    localparam int OUT_MIN   = -(1 << (OUT_DW - 1));

    // Default decode: weighted bit count, shifted down by half the output range.
    function automatic logic signed [OUT_DW-1:0] default_entry(input logic [IN_DW-1:0] code);
        int sum;
        sum = OUT_MIN;
        for (int k = 0; k < IN_DW; k++) begin
            if (code[k]) sum += k + 1;
        end
        if (sum > OUT_MAX)      sum = OUT_MAX;
        else if (sum < OUT_MIN) sum = OUT_MIN;
        return OUT_DW'(sum);
    endfunction

    // ------------------------------------------------------------------------
    // Decode table
    // ------------------------------------------------------------------------
    logic signed [OUT_DW-1:0] lut [LUT_DEPTH];

`ifdef DECODER_LUT_WR_EN
    // NOTE: this table is reset on purpose - after reset it must hold the
    // default contents again, so every entry takes its default on rst_n.
    // A write lands at the clock edge, so a lookup at that same edge still
    // sees the old entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < LUT_DEPTH; i++) begin
                lut[i] <= default_entry(IN_DW'(i));
            end
        end else if (cfg_we) begin
            lut[cfg_addr] <= cfg_data;
        end
    end
`else
    for (genvar i = 0; i < LUT_DEPTH; i++) begin : g_rom
        assign lut[i] = default_entry(IN_DW'(i));
    end
`endif

    // ------------------------------------------------------------------------
    // Flow control
    // ------------------------------------------------------------------------
    logic v1, v2;
    logic en1, en2;

    // A stage may load when it is empty or when its contents move on in this
    // cycle. This lets a full pipeline accept and deliver in the same cycle.
    assign en2        = !v2 || out_ready;
    assign en1        = !v1 || en2;
    assign data_ready = en1;
    assign data_e_out = v2;

    // ------------------------------------------------------------------------
    // Stage 1: capture raw codes
    // ------------------------------------------------------------------------
    logic [IN_DW-1:0] s1_code [CHANNEL_NUM][MACRO_NUM];

    // NOTE: sequential state uses non-blocking assignments only, so every
    // stage samples the values that stood before the clock edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)   v1 <= 1'b0;
        else if (en1) v1 <= data_e;
    end

    // NOTE: the stage-1 code registers have no reset. v1 alone says whether
    // they hold a valid beat, so resetting this wide array would add nothing.
    always_ff @(posedge clk) begin
        if (en1 && data_e) s1_code <= data_in;
    end

    // ------------------------------------------------------------------------
    // Stage 2: shared-table lookup into the output registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v2 <= 1'b0;
            for (int c = 0; c < CHANNEL_NUM; c++) begin
                for (int m = 0; m < MACRO_NUM; m++) begin
                    data_out[c][m] <= '0;
                end
            end
        end else if (en2) begin
            v2 <= v1;
            if (v1) begin
                for (int c = 0; c < CHANNEL_NUM; c++) begin
                    for (int m = 0; m < MACRO_NUM; m++) begin
                        data_out[c][m] <= lut[s1_code[c][m]];
                    end
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // Delivered-beat counter (wraps naturally)
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                    beat_cnt <= '0;
        else if (v2 && out_ready)      beat_cnt <= beat_cnt + CNT_DW'(1);
    end

endmodule

// File: tb/tb_decoder_lut_pipe.sv
// ----------------------------------------------------------------------------
// Testbench for decoder_lut_pipe on a small lane array (2 x 8) with a 4-bit
// beat counter. A transaction-level model keeps the in-flight beats in a
// queue. Each beat is decoded from the spec formula (or from the written
// table) once it has spent one edge in the pipe. A negedge compare process
// checks valid, ready, count and data against this model. Directed steps add
// literal expectations.
// ----------------------------------------------------------------------------
module tb_decoder_lut_pipe;

    localparam int CH     = 2;
    localparam int MA     = 8;
    localparam int IN_DW  = 5;
    localparam int OUT_DW = 4;
    localparam int CNT_DW = 4;
    localparam int LANES  = CH * MA;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic data_e = 1'b0;
    logic out_ready = 1'b0;
    logic data_ready, data_e_out;
    logic [IN_DW-1:0]         data_in  [CH][MA];
    logic signed [OUT_DW-1:0] data_out [CH][MA];
    logic [CNT_DW-1:0]        beat_cnt;
`ifdef DECODER_LUT_WR_EN
    logic                     cfg_we = 1'b0;
    logic [IN_DW-1:0]         cfg_addr = '0;
    logic signed [OUT_DW-1:0] cfg_data = '0;
`endif

    decoder_lut_pipe #(
        .CHANNEL_NUM(CH), .MACRO_NUM(MA), .IN_DW(IN_DW), .OUT_DW(OUT_DW), .CNT_DW(CNT_DW)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .data_e(data_e),
        .data_ready(data_ready),
        .data_in(data_in),
        .data_out(data_out),
        .data_e_out(data_e_out),
        .out_ready(out_ready),
`ifdef DECODER_LUT_WR_EN
        .cfg_we(cfg_we),
        .cfg_addr(cfg_addr),
        .cfg_data(cfg_data),
`endif
        .beat_cnt(beat_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit started = 1'b0;

    task automatic check(input string name, input logic signed [63:0] act,
                         input logic signed [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t",
                     name, act, act, exp, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int ref_default(input int code);
        int s = -(1 << (OUT_DW - 1));
        for (int k = 0; k < IN_DW; k++) begin
            if (code[k]) s += k + 1;
        end
        if (s > (1 << (OUT_DW - 1)) - 1) s = (1 << (OUT_DW - 1)) - 1;
        if (s < -(1 << (OUT_DW - 1)))    s = -(1 << (OUT_DW - 1));
        return s;
    endfunction

    typedef struct {
        logic [LANES*IN_DW-1:0]  codes;
        logic [LANES*OUT_DW-1:0] vals;
        int                      acc_edge;
        bit                      decoded;
    } beat_t;

    beat_t q[$];
    int    edge_n = 0;
    int    m_cnt = 0;
    int    m_tbl [1 << IN_DW];

    function automatic logic [LANES*IN_DW-1:0] flat_in();
        logic [LANES*IN_DW-1:0] f;
        for (int c = 0; c < CH; c++)
            for (int m = 0; m < MA; m++)
                f[(c*MA+m)*IN_DW +: IN_DW] = data_in[c][m];
        return f;
    endfunction

    function automatic logic [LANES*OUT_DW-1:0] flat_out();
        logic [LANES*OUT_DW-1:0] f;
        for (int c = 0; c < CH; c++)
            for (int m = 0; m < MA; m++)
                f[(c*MA+m)*OUT_DW +: OUT_DW] = data_out[c][m];
        return f;
    endfunction

    // The model holds up to two beats. The front beat is presented once it
    // has been in the pipe for at least one edge, and it is decoded at that
    // edge with the table contents from before any write at that same edge.
    always @(posedge clk or negedge rst_n) begin
        bit    vis, rdy;
        beat_t b;
        if (!rst_n) begin
            q.delete();
            m_cnt = 0;
            for (int i = 0; i < (1 << IN_DW); i++) m_tbl[i] = ref_default(i);
        end else begin
            edge_n++;
            vis = (q.size() > 0) && q[0].decoded;
            rdy = (q.size() < 2) || out_ready;
            if (vis && out_ready) begin
                void'(q.pop_front());
                m_cnt = (m_cnt + 1) % (1 << CNT_DW);
            end
            if (data_e && rdy) begin
                b.codes = flat_in();
                b.vals = '0;
                b.acc_edge = edge_n;
                b.decoded = 1'b0;
                q.push_back(b);
            end
            if (q.size() > 0 && !q[0].decoded && q[0].acc_edge < edge_n) begin
                b = q[0];
                for (int l = 0; l < LANES; l++)
                    b.vals[l*OUT_DW +: OUT_DW] = OUT_DW'(m_tbl[b.codes[l*IN_DW +: IN_DW]]);
                b.decoded = 1'b1;
                q[0] = b;
            end
`ifdef DECODER_LUT_WR_EN
            if (cfg_we) m_tbl[cfg_addr] = int'(cfg_data);
`endif
        end
    end

    // Compare process: every cycle, away from the active edge.
    always @(negedge clk) begin
        bit vis;
        if (started) begin
            vis = (q.size() > 0) && q[0].decoded;
            check("model_data_e_out", data_e_out, vis);
            check("model_data_ready", data_ready, (q.size() < 2) || out_ready);
            check("model_beat_cnt", beat_cnt, m_cnt);
            if (vis) check("model_data_out", flat_out(), q[0].vals);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [IN_DW-1:0] code_of(input int beat, input int c, input int m);
        return IN_DW'((beat * 5 + c * 3 + m) % 32);
    endfunction

    task automatic drive_beat(input int beat);
        for (int c = 0; c < CH; c++)
            for (int m = 0; m < MA; m++)
                data_in[c][m] = code_of(beat, c, m);
        data_e = 1'b1;
    endtask

    task automatic drive_zero();
        for (int c = 0; c < CH; c++)
            for (int m = 0; m < MA; m++)
                data_in[c][m] = '0;
        data_e = 1'b1;
    endtask

    task automatic do_reset();
        data_e = 1'b0;
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        #1;
    endtask

    initial begin
        int pin_codes [6];
        int pin_exp   [6];
        int beat;
        int acc;
        bit acc_now;
        pin_codes = '{0, 3, 4, 12, 13, 31};
        pin_exp   = '{-8, -5, -5, -1, 0, 7};

        for (int c = 0; c < CH; c++)
            for (int m = 0; m < MA; m++)
                data_in[c][m] = '0;

        // Reset state.
        rst_n = 1'b0;
        tick();
        tick();
        check("rst_data_e_out", data_e_out, 0);
        check("rst_beat_cnt", beat_cnt, 0);
        check("rst_data_out", flat_out(), 0);
        rst_n = 1'b1;
        #1;
        check("rst_data_ready", data_ready, 1);
        started = 1'b1;

        // Pinned decode values, 2-cycle latency, count after delivery.
        out_ready = 1'b1;
        drive_zero();
        for (int i = 0; i < 6; i++) data_in[0][i] = IN_DW'(pin_codes[i]);
        tick();
        data_e = 1'b0;
        check("lat_cycle1_valid", data_e_out, 0);
        tick();
        check("lat_cycle2_valid", data_e_out, 1);
        for (int i = 0; i < 6; i++)
            check($sformatf("decode_code_%0d", pin_codes[i]), $signed(data_out[0][i]), pin_exp[i]);
        tick();
        check("first_beat_cnt", beat_cnt, 1);
        check("first_beat_gone", data_e_out, 0);

        // Ten back-to-back beats.
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            drive_beat(i);
            tick();
            check($sformatf("stream_valid_%0d", i), data_e_out, (i == 0) ? 0 : 1);
        end
        data_e = 1'b0;
        tick();
        check("stream_last_valid", data_e_out, 1);
        tick();
        check("stream_done_valid", data_e_out, 0);
        check("stream_beat_cnt", beat_cnt, 10);

        // Backpressure: absorbs exactly two beats, then drains in order.
        do_reset();
        out_ready = 1'b0;
        beat = 0;
        acc = 0;
        for (int k = 0; k < 4; k++) begin
            drive_beat(beat);
            acc_now = data_ready;
            tick();
            if (acc_now) begin
                beat++;
                acc++;
            end
        end
        check("bp_absorbed", acc, 2);
        check("bp_ready_low", data_ready, 0);
        check("bp_valid_held", data_e_out, 1);
        out_ready = 1'b1;
        #1;
        check("bp_simul_ready", data_ready, 1);
        for (int k = 0; k < 20 && beat < 6; k++) begin
            drive_beat(beat);
            acc_now = data_ready;
            tick();
            if (acc_now) beat++;
        end
        check("bp_all_accepted", beat, 6);
        data_e = 1'b0;
        tick();
        tick();
        tick();
        check("bp_beat_cnt", beat_cnt, 6);
        check("bp_drained", data_e_out, 0);

`ifdef DECODER_LUT_WR_EN
        // Table write: a lookup at the write edge sees the old entry.
        do_reset();
        out_ready = 1'b1;
        drive_zero();
        tick();
        cfg_we = 1'b1;
        cfg_addr = '0;
        cfg_data = 4'sd3;
        tick();
        data_e = 1'b0;
        cfg_we = 1'b0;
        check("wr_same_cycle_old", $signed(data_out[0][0]), -8);
        tick();
        check("wr_new_entry", $signed(data_out[0][0]), 3);
        tick();
`endif

        // Reset mid-operation with both stages full.
        out_ready = 1'b0;
        drive_beat(3);
        tick();
        drive_beat(4);
        tick();
        data_e = 1'b0;
        check("mid_full_valid", data_e_out, 1);
        check("mid_full_ready", data_ready, 0);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", data_e_out, 0);
        check("mid_rst_data_out", flat_out(), 0);
        check("mid_rst_beat_cnt", beat_cnt, 0);
        tick();
        rst_n = 1'b1;
        #1;
        check("post_rst_ready", data_ready, 1);
        out_ready = 1'b1;
        drive_zero();
        tick();
        data_e = 1'b0;
        tick();
        check("post_rst_default_code0", $signed(data_out[0][0]), -8);
        tick();

        // Counter wrap with a 4-bit counter: 17 beats leave the count at 1.
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 17; i++) begin
            drive_beat(i);
            tick();
        end
        data_e = 1'b0;
        tick();
        tick();
        tick();
        check("wrap_beat_cnt", beat_cnt, 1);

        started = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
